// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic for MixColumns plus the sequencer state type.
package aes_pkg;

    localparam int AES_STATE_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mc_state_e;

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Only the constant multipliers MixColumns needs; any other c yields zero.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] c);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(b);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        case (c)
            8'h01:   return b;
            8'h02:   return x2;
            8'h03:   return x2 ^ b;
            8'h09:   return x8 ^ b;
            8'h0b:   return x8 ^ x2 ^ b;
            8'h0d:   return x8 ^ x4 ^ b;
            8'h0e:   return x8 ^ x4 ^ x2;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// One AES state column through the forward or inverse MixColumns matrix.
module mix_column_word
    import aes_pkg::*;
(
    input  logic [31:0] col,
    input  logic        inv,
    output logic [31:0] result
);

    // Row 0 of each circulant matrix; row r is this rotated right by r.
    localparam logic [3:0][7:0] FWD_ROW = {8'h02, 8'h03, 8'h01, 8'h01};
    localparam logic [3:0][7:0] INV_ROW = {8'h0e, 8'h0b, 8'h0d, 8'h09};

    logic [3:0][7:0] a, fwd, bwd;

    assign a = col;

    always_comb begin
        fwd = '0;
        bwd = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                fwd[3-r] = fwd[3-r] ^ gf_mul(a[3-((r+j)%4)], FWD_ROW[3-j]);
                bwd[3-r] = bwd[3-r] ^ gf_mul(a[3-((r+j)%4)], INV_ROW[3-j]);
            end
        end
    end

    assign result = inv ? bwd : fwd;

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential MixColumns/InvMixColumns over a 128-bit AES state, COLS_PER_CYCLE columns per clock.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter int SUPPORT_INV    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_inv,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state
);

    localparam int N     = 4 / COLS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    mc_state_e state, state_nxt;
    logic [AES_STATE_W-1:0] st_q, st_nxt;
    logic [CNT_W-1:0] cnt;
    logic inv_q;
    logic accept, last;
    logic [COLS_PER_CYCLE-1:0][31:0] col_in, col_out;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == CNT_LAST);
    assign out_valid = (state == DONE);
    assign out_state = st_q;

    // Column 0 sits in the top word, so column c lives at bits [32*(3-c) +: 32].
    always_comb begin
        col_in = '0;
        for (int k = 0; k < COLS_PER_CYCLE; k++)
            col_in[k] = st_q[32*(3 - int'(cnt)*COLS_PER_CYCLE - k) +: 32];
    end

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        mix_column_word u_mcw (
            .col    (col_in[k]),
            .inv    (inv_q),
            .result (col_out[k])
        );
    end

    always_comb begin
        st_nxt = st_q;
        for (int k = 0; k < COLS_PER_CYCLE; k++)
            st_nxt[32*(3 - int'(cnt)*COLS_PER_CYCLE - k) +: 32] = col_out[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = accept ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= '0;
            inv_q <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            st_q  <= in_state;
            inv_q <= (SUPPORT_INV != 0) && in_inv;
            cnt   <= '0;
        end else if (state == BUSY) begin
            st_q <= st_nxt;
            cnt  <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: instances at 1, 2, 4 columns/cycle plus a forward-only build.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         iv   [4];
    logic         ir   [4];
    logic         iinv [4];
    logic [127:0] ist  [4];
    logic         ov   [4];
    logic         ordy [4];
    logic [127:0] os   [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mix_columns_seq #(
            .COLS_PER_CYCLE ((g == 3) ? 1 : (1 << g)),
            .SUPPORT_INV    ((g == 3) ? 0 : 1)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_inv    (iinv[g]),
            .in_state  (ist[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_state (os[g])
        );
    end

    // Reference: generic shift-and-add GF(2^8) multiply and explicit matrix product.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] x;
        logic [7:0] p;
        p = 0;
        x = {1'b0, a};
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x[7:0];
            x = x << 1;
            if (x[8]) x = x ^ 9'h11b;
        end
        return p;
    endfunction

    function automatic logic [127:0] mc_ref(input logic [127:0] s, input logic inv);
        logic [7:0] coef [4];
        logic [7:0] a [4];
        logic [7:0] o;
        logic [127:0] res;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        res = 0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127 - 32*c - 8*r -: 8];
            for (int r = 0; r < 4; r++) begin
                o = 0;
                for (int j = 0; j < 4; j++) o = o ^ gmul(coef[(j - r + 4) % 4], a[j]);
                res[127 - 32*c - 8*r -: 8] = o;
            end
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for out_valid, sampling 1 time unit after each rising edge.
    task automatic wait_ov(input int d, output int lat);
        lat = 0;
        while (ov[d] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_one(input int d, input logic [127:0] s, input logic inv,
                           output logic [127:0] r, output int lat);
        int guard = 0;
        @(negedge clk);
        ist[d] = s; iinv[d] = inv; iv[d] = 1'b1; ordy[d] = 1'b1;
        while (ir[d] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", {127'd0, ir[d]}, 128'd1);
        @(posedge clk); #1;
        iv[d] = 1'b0;
        wait_ov(d, lat);
        r = os[d];
    endtask

    task automatic rand_run(input int d, input int n);
        logic [127:0] q [$];
        logic [127:0] s;
        int sent = 0, got = 0, cyc = 0;
        logic acc, oxf;
        iv[d] = 1'b0;
        while (got < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            ordy[d] = ($urandom_range(0, 3) != 0);
            if (!iv[d] && sent < n) begin
                s = {$urandom, $urandom, $urandom, $urandom};
                ist[d] = s; iinv[d] = $urandom_range(0, 1); iv[d] = 1'b1;
            end
            #1;
            acc = iv[d] && ir[d];
            oxf = ov[d] && ordy[d];
            if (oxf) begin
                checks++;
                assert (q.size() > 0) else begin
                    errors++;
                    $error("FAIL rand_extra observed %h expected no output", os[d]);
                end
                if (q.size() > 0) begin
                    chk("rand_data", os[d], q.pop_front());
                    got++;
                end
            end
            if (acc) begin
                q.push_back(mc_ref(ist[d], iinv[d]));
                sent++;
            end
            @(posedge clk); #1;
            if (acc) iv[d] = 1'b0;
        end
        chk("rand_count", 128'(got), 128'(n));
        chk("rand_left", 128'(q.size()), 128'd0);
    endtask

    initial begin
        logic [127:0] a, b, r, r2, hold;
        int lat;
        bit seen;
        for (int d = 0; d < 4; d++) begin
            iv[d] = 0; iinv[d] = 0; ist[d] = 0; ordy[d] = 1;
        end

        // Reset state and ready right after release
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            chk("rst_ov", {127'd0, ov[d]}, 128'd0);
            chk("rst_os", os[d], 128'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 4; d++) chk("rst_ready", {127'd0, ir[d]}, 128'd1);

        // Known vector, forward then inverse, at every width
        a = {32'hdb135345, 32'h01010101, 32'h01010101, 32'h01010101};
        b = {32'h8e4da1bc, 32'h01010101, 32'h01010101, 32'h01010101};
        for (int d = 0; d < 3; d++) begin
            run_one(d, a, 1'b0, r, lat);
            chk("fwd_vec", r, b);
            chk("fwd_lat", 128'(lat), 128'(4 >> d));
            run_one(d, r, 1'b1, r2, lat);
            chk("inv_restore", r2, a);
            chk("inv_lat", 128'(lat), 128'(4 >> d));
        end

        a = {32'hd4d4d4d5, 32'h2d26314c, 32'hc6c6c6c6, 32'hf20a225c};
        b = {32'hd5d5d7d6, 32'h4d7ebdf8, 32'hc6c6c6c6, 32'h9fdc589d};
        run_one(0, a, 1'b0, r, lat);
        chk("fips_vec", r, b);
        run_one(2, a, 1'b0, r, lat);
        chk("fips_vec_w4", r, b);

        // Forward-only build ignores in_inv
        run_one(3, a, 1'b1, r, lat);
        chk("noinv_fwd", r, b);

        // Backpressure in DONE, then same-edge output and input transfers
        repeat (2) @(negedge clk);
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        ordy[0] = 1'b0; iv[0] = 1'b1; ist[0] = a; iinv[0] = 1'b0;
        @(posedge clk); #1;
        ist[0] = b; iinv[0] = 1'b1;
        wait_ov(0, lat);
        chk("stall_lat", 128'(lat), 128'd4);
        hold = mc_ref(a, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_os", os[0], hold);
            chk("stall_ready", {127'd0, ir[0]}, 128'd0);
            chk("stall_ov", {127'd0, ov[0]}, 128'd1);
        end
        @(negedge clk); ordy[0] = 1'b1;
        #1 chk("release_ready", {127'd0, ir[0]}, 128'd1);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        chk("release_ov", {127'd0, ov[0]}, 128'd0);
        wait_ov(0, lat);
        chk("release_lat", 128'(lat), 128'd4);
        chk("release_data", os[0], mc_ref(b, 1'b1));

        // Reset pulsed in the middle of BUSY
        repeat (2) @(negedge clk);
        @(negedge clk);
        iv[0] = 1'b1; ist[0] = a; iinv[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ov", {127'd0, ov[0]}, 128'd0);
        chk("midrst_os", os[0], 128'd0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ov[0]) seen = 1;
        end
        chk("midrst_no_out", {127'd0, seen}, 128'd0);
        run_one(0, a, 1'b0, r, lat);
        chk("midrst_next", r, mc_ref(a, 1'b0));
        chk("midrst_lat", 128'(lat), 128'd4);

        // Random traffic with random backpressure and direction
        repeat (2) @(negedge clk);
        rand_run(0, 100);
        repeat (3) @(negedge clk);
        rand_run(1, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
